// File: rtl/apb_mem_pkg.sv
// Shared types and default sizing for the APB-to-memory bridge.
//   state_e          : bridge FSM states
//   DefaultAw/Dw     : default address / data widths
//   DefaultMemDepth  : default number of valid memory words
package apb_mem_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StStrobe,
        StRdCap,
        StDone
    } state_e;

    localparam int unsigned DefaultAw       = 8;
    localparam int unsigned DefaultDw       = 8;
    localparam int unsigned DefaultMemDepth = 256;

endpackage

// File: rtl/apb_mem_bridge.sv
// APB completer driving a single-port synchronous memory with one-cycle strobes.
// Writes complete with one wait state, reads with two (registered memory read),
// out-of-range addresses complete immediately with pslverr and no memory access.
//   clk, rst_n          : clock, asynchronous active-low reset
//   psel .. pwdata      : APB request inputs
//   prdata/pready/pslverr : APB response outputs (registered)
//   mem_addr .. mem_wr_data : memory request outputs (registered)
//   mem_rd_data         : memory read data, valid the cycle after a read strobe
module apb_mem_bridge
    import apb_mem_pkg::*;
#(
    parameter int unsigned MEM_DEPTH = DefaultMemDepth,
    parameter int unsigned AW        = DefaultAw,
    parameter int unsigned DW        = DefaultDw
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          psel,
    input  logic          penable,
    input  logic          pwrite,
    input  logic [AW-1:0] paddr,
    input  logic [DW-1:0] pwdata,
    output logic [DW-1:0] prdata,
    output logic          pready,
    output logic          pslverr,
    output logic [AW-1:0] mem_addr,
    output logic          mem_ce,
    output logic          mem_wren,
    output logic          mem_rden,
    output logic [DW-1:0] mem_wr_data,
    input  logic [DW-1:0] mem_rd_data
);

    // One extra bit so MEM_DEPTH == 2**AW is representable and never flags an error.
    localparam logic [AW:0] DepthLim = (AW+1)'(MEM_DEPTH);

    state_e state;
    logic   in_range;

    assign in_range = ({1'b0, paddr} < DepthLim);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= StIdle;
            prdata      <= '0;
            pready      <= 1'b0;
            pslverr     <= 1'b0;
            mem_addr    <= '0;
            mem_ce      <= 1'b0;
            mem_wren    <= 1'b0;
            mem_rden    <= 1'b0;
            mem_wr_data <= '0;
        end else begin
            case (state)
                StIdle: begin
                    // Only a setup phase starts a transfer; a stray penable is ignored.
                    if (psel && !penable) begin
                        mem_addr    <= paddr;
                        mem_wr_data <= pwdata;
                        if (in_range) begin
                            state    <= StStrobe;
                            mem_ce   <= 1'b1;
                            mem_wren <= pwrite;
                            mem_rden <= !pwrite;
                        end else begin
                            state   <= StDone;
                            pready  <= 1'b1;
                            pslverr <= 1'b1;
                        end
                    end
                end
                StStrobe: begin
                    mem_ce   <= 1'b0;
                    mem_wren <= 1'b0;
                    mem_rden <= 1'b0;
                    // mem_wren still holds the direction of the strobe being issued.
                    if (!psel) begin
                        state <= StIdle;
                    end else if (mem_wren) begin
                        state  <= StDone;
                        pready <= 1'b1;
                    end else begin
                        state <= StRdCap;
                    end
                end
                StRdCap: begin
                    if (!psel) begin
                        state <= StIdle;
                    end else begin
                        prdata <= mem_rd_data;
                        pready <= 1'b1;
                        state  <= StDone;
                    end
                end
                StDone: begin
                    pready  <= 1'b0;
                    pslverr <= 1'b0;
                    state   <= StIdle;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_mem_bridge.sv
// Self-checking bench: APB BFM + behavioural 256x8 memory behind the bridge,
// scoreboard of expected responses popped when pready is seen.
module tb_apb_mem_bridge;

    logic       clk;
    logic       rst_n;
    logic       psel;
    logic       psel2;
    logic       penable;
    logic       pwrite;
    logic [7:0] paddr;
    logic [7:0] pwdata;

    logic [7:0] prdata,  prdata2;
    logic       pready,  pready2;
    logic       pslverr, pslverr2;
    logic [7:0] mem_addr, mem_addr2;
    logic       mem_ce, mem_ce2;
    logic       mem_wren, mem_wren2;
    logic       mem_rden, mem_rden2;
    logic [7:0] mem_wr_data, mem_wr_data2;
    logic [7:0] mem_rd_data;

    logic [7:0] mem [256];

    apb_mem_bridge #(
        .MEM_DEPTH (256),
        .AW        (8),
        .DW        (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .psel        (psel),
        .penable     (penable),
        .pwrite      (pwrite),
        .paddr       (paddr),
        .pwdata      (pwdata),
        .prdata      (prdata),
        .pready      (pready),
        .pslverr     (pslverr),
        .mem_addr    (mem_addr),
        .mem_ce      (mem_ce),
        .mem_wren    (mem_wren),
        .mem_rden    (mem_rden),
        .mem_wr_data (mem_wr_data),
        .mem_rd_data (mem_rd_data)
    );

    // Reduced-depth instance for the address-error path; its memory always reads 0x5A.
    apb_mem_bridge #(
        .MEM_DEPTH (128),
        .AW        (8),
        .DW        (8)
    ) dut2 (
        .clk         (clk),
        .rst_n       (rst_n),
        .psel        (psel2),
        .penable     (penable),
        .pwrite      (pwrite),
        .paddr       (paddr),
        .pwdata      (pwdata),
        .prdata      (prdata2),
        .pready      (pready2),
        .pslverr     (pslverr2),
        .mem_addr    (mem_addr2),
        .mem_ce      (mem_ce2),
        .mem_wren    (mem_wren2),
        .mem_rden    (mem_rden2),
        .mem_wr_data (mem_wr_data2),
        .mem_rd_data (8'h5A)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous memory with registered read.
    always @(posedge clk) begin
        if (mem_ce) begin
            if (mem_wren) mem[mem_addr] <= mem_wr_data;
            if (mem_rden) mem_rd_data <= mem[mem_addr];
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    int cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    typedef struct {
        logic       wr;
        logic [7:0] rdata;
        int         start;
        int         lat;
    } sb_t;

    sb_t sb[$];
    sb_t mon_e;

    int ce_cnt    = 0;
    int ce2_cnt   = 0;
    int ce_long   = 0;
    int overlap   = 0;
    int pready_cnt = 0;
    logic ce_prev = 1'b0;

    always @(negedge clk) begin
        if (mem_ce) ce_cnt <= ce_cnt + 1;
        if (mem_ce2) ce2_cnt <= ce2_cnt + 1;
        if (mem_ce && ce_prev) ce_long <= ce_long + 1;
        ce_prev <= mem_ce;
        if ((mem_wren && mem_rden) || (mem_wren2 && mem_rden2)) overlap <= overlap + 1;
        if (pready) pready_cnt <= pready_cnt + 1;
    end

    // Scoreboard: every pready on the main instance must match the oldest expectation.
    always @(negedge clk) begin
        if (pready) begin
            if (sb.size() == 0) begin
                check_eq("sb_unexpected_pready", 32'(pready), 32'h0);
            end else begin
                mon_e = sb.pop_front();
                check_eq("latency", 32'(cycle - mon_e.start), 32'(mon_e.lat));
                check_eq("pslverr", 32'(pslverr), 32'h0);
                if (!mon_e.wr) check_eq("prdata", 32'(prdata), 32'(mon_e.rdata));
            end
        end
    end

    // Caller is #1 after a posedge; leaves at #1 after the completing posedge so
    // consecutive calls are back-to-back.
    task automatic apb_xfer(input logic wr, input logic [7:0] addr, input logic [7:0] data,
                            input logic [7:0] exp_rd);
        sb_t e;
        bit  done;
        e.wr    = wr;
        e.rdata = exp_rd;
        e.start = cycle;
        e.lat   = wr ? 2 : 3;
        sb.push_back(e);
        psel    = 1'b1;
        penable = 1'b0;
        pwrite  = wr;
        paddr   = addr;
        pwdata  = data;
        @(posedge clk);
        #1 penable = 1'b1;
        done = 1'b0;
        for (int i = 0; i < 8 && !done; i++) begin
            @(negedge clk);
            if (pready) done = 1'b1;
        end
        if (!done) begin
            check_eq("xfer_timeout", 32'h0, 32'h1);
            if (sb.size() != 0) e = sb.pop_back();
        end
        @(posedge clk);
        #1;
        psel    = 1'b0;
        penable = 1'b0;
    endtask

    task automatic apb2_read(input logic [7:0] addr, output int lat, output logic err,
                             output logic [7:0] rd);
        int  start;
        bit  done;
        start   = cycle;
        psel2   = 1'b1;
        penable = 1'b0;
        pwrite  = 1'b0;
        paddr   = addr;
        @(posedge clk);
        #1 penable = 1'b1;
        done = 1'b0;
        lat  = -1;
        err  = 1'b0;
        rd   = 8'h00;
        for (int i = 0; i < 8 && !done; i++) begin
            @(negedge clk);
            if (pready2) begin
                done = 1'b1;
                lat  = cycle - start;
                err  = pslverr2;
                rd   = prdata2;
            end
        end
        @(posedge clk);
        #1;
        psel2   = 1'b0;
        penable = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    int         ce_before;
    int         pr_before;
    int         lat2;
    logic       err2;
    logic [7:0] rd2;

    initial begin
        rst_n   = 1'b0;
        psel    = 1'b0;
        psel2   = 1'b0;
        penable = 1'b0;
        pwrite  = 1'b0;
        paddr   = 8'h00;
        pwdata  = 8'h00;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        check_eq("reset_outs", {3'b0, prdata, pready, pslverr, mem_addr, mem_ce, mem_wren,
                                mem_rden, mem_wr_data}, 32'h0);
        check_eq("reset_outs2", {3'b0, prdata2, pready2, pslverr2, mem_addr2, mem_ce2,
                                 mem_wren2, mem_rden2, mem_wr_data2}, 32'h0);
        idle(1);

        // Stray penable without setup: no strobe, no pready.
        ce_before = ce_cnt;
        psel = 1'b1;
        penable = 1'b1;
        idle(3);
        psel = 1'b0;
        penable = 1'b0;
        idle(1);
        check_eq("stray_penable_ce", 32'(ce_cnt - ce_before), 32'h0);

        // Basic write then read.
        ce_before = ce_cnt;
        apb_xfer(1'b1, 8'h10, 8'hA5, 8'h00);
        idle(1);
        apb_xfer(1'b0, 8'h10, 8'h00, 8'hA5);
        idle(1);
        check_eq("ce_pulses_wr_rd", 32'(ce_cnt - ce_before), 32'h2);

        // Address extremes.
        apb_xfer(1'b1, 8'h00, 8'hFF, 8'h00);
        apb_xfer(1'b1, 8'hFF, 8'h00, 8'h00);
        apb_xfer(1'b0, 8'h00, 8'h00, 8'hFF);
        apb_xfer(1'b0, 8'hFF, 8'h00, 8'h00);
        idle(1);

        // Reduced-depth instance: in-range read, then out-of-range error.
        apb2_read(8'h05, lat2, err2, rd2);
        check_eq("d128_ok_lat", 32'(lat2), 32'd3);
        check_eq("d128_ok_err", 32'(err2), 32'h0);
        check_eq("d128_ok_rd", 32'(rd2), 32'h5A);
        idle(1);
        ce_before = ce2_cnt;
        apb2_read(8'h80, lat2, err2, rd2);
        check_eq("d128_err_lat", 32'(lat2), 32'd1);
        check_eq("d128_err_slverr", 32'(err2), 32'h1);
        check_eq("d128_err_prdata", 32'(rd2), 32'h5A);
        idle(2);
        check_eq("d128_err_no_ce", 32'(ce2_cnt - ce_before), 32'h0);
        check_eq("d128_prdata_hold", 32'(prdata2), 32'h5A);

        // Back-to-back write then read.
        apb_xfer(1'b1, 8'h05, 8'h3C, 8'h00);
        apb_xfer(1'b0, 8'h05, 8'h00, 8'h3C);
        idle(1);

        // Abort a write by dropping psel during the strobe cycle.
        pr_before = pready_cnt;
        psel    = 1'b1;
        penable = 1'b0;
        pwrite  = 1'b1;
        paddr   = 8'h20;
        pwdata  = 8'h77;
        @(posedge clk);
        #1;
        check_eq("abort_strobe_seen", {mem_ce, mem_wren}, 32'h3);
        psel    = 1'b0;
        penable = 1'b0;
        idle(4);
        check_eq("abort_no_pready", 32'(pready_cnt - pr_before), 32'h0);
        apb_xfer(1'b0, 8'h20, 8'h00, 8'h77);
        idle(1);

        // Reset while waiting in the read-capture cycle.
        psel    = 1'b1;
        penable = 1'b0;
        pwrite  = 1'b0;
        paddr   = 8'h10;
        @(posedge clk);
        #1 penable = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("async_reset_outs", {3'b0, prdata, pready, pslverr, mem_addr, mem_ce, mem_wren,
                                      mem_rden, mem_wr_data}, 32'h0);
        psel    = 1'b0;
        penable = 1'b0;
        idle(2);
        rst_n = 1'b1;
        idle(1);
        apb_xfer(1'b0, 8'h10, 8'h00, 8'hA5);
        idle(2);

        check_eq("strobe_overlap", 32'(overlap), 32'h0);
        check_eq("ce_multi_cycle", 32'(ce_long), 32'h0);
        check_eq("sb_leftover", 32'(sb.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/apb_mem_bridge.md
# apb_mem_bridge

APB completer that turns APB read/write transfers into single-cycle accesses on the 8-bit synchronous memory port (`addr`/`ce`/`wren`/`rden`/`wr_data`/`rd_data`). It is the initiator for the memory array and the responder for the APB initiator. It inserts the wait states the registered memory read needs and flags out-of-range addresses with `pslverr`.

## Interface
- `MEM_DEPTH`, default 256: number of valid memory words; `paddr >= MEM_DEPTH` is an error.
- `AW`, default 8: address width on both sides.
- `DW`, default 8: data width on both sides.

Ports:
- `clk` in 1: single clock; all logic on posedge.
- `rst_n` in 1: asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- `psel` in 1: APB select.
- `penable` in 1: APB access phase.
- `pwrite` in 1: 1 = write, 0 = read.
- `paddr` in AW: APB address.
- `pwdata` in DW: APB write data.
- `prdata` out DW: APB read data, registered.
- `pready` out 1: transfer complete, registered.
- `pslverr` out 1: error response, valid only when `pready` = 1.
- `mem_addr` out AW: memory address, registered.
- `mem_ce` out 1: memory chip enable, one-cycle pulse.
- `mem_wren` out 1: memory write strobe.
- `mem_rden` out 1: memory read strobe.
- `mem_wr_data` out DW: memory write data.
- `mem_rd_data` in DW: memory read data, valid on the cycle after a `mem_ce`&`mem_rden` edge.

## Operation
- FSM states: IDLE, STROBE, RD_CAP, DONE.
- IDLE:
  - on `psel`&!`penable` (setup phase), register `paddr`/`pwdata`/`pwrite` into `mem_addr`/`mem_wr_data`.
  - in range: go to STROBE with `mem_ce`=1, `mem_wren`=`pwrite`, `mem_rden`=!`pwrite`.
  - out of range: go to DONE with `pslverr`=1 and no strobe.
- STROBE: lasts exactly one cycle with the strobes high; strobes deassert on exit.
  - write: go to DONE.
  - read: go to RD_CAP.
- RD_CAP: `prdata` <= `mem_rd_data`; go to DONE.
- DONE: `pready`=1 for exactly one cycle, then IDLE; `pslverr` and `pready` clear on exit.
- `mem_wren` and `mem_rden` are never both 1. Strobes are only ever high in STROBE.
- `prdata` holds its last captured value between reads. It is not updated on writes or on error reads.
- Penable without a preceding setup (penable=1 in IDLE with no latched setup) is ignored; no strobe.
- `psel` dropping in STROBE/RD_CAP aborts to IDLE with no `pready`. A strobe already issued is not retracted; the memory write still occurs.
- Back-to-back: a new setup phase is accepted in the cycle after DONE (IDLE sampling).

## Timing
- Reset values: `prdata`=0, `pready`=0, `pslverr`=0, `mem_addr`=0, `mem_ce`=0, `mem_wren`=0, `mem_rden`=0, `mem_wr_data`=0, state=IDLE.
- Reset mid-transfer drops all outputs asynchronously. No memory write completes unless its strobe edge was already sampled.
- Cycle numbering: T0 = setup cycle; the first access cycle is T1.
- Write: strobe high in T1, memory writes at the end of T1, `pready`=1 in T2. That is 1 wait state, 3 cycles total.
- Read: strobe high in T1, `mem_rd_data` valid in T2 and captured at the end of T2, `prdata` valid and `pready`=1 in T3. That is 2 wait states.
- Error: `pready`=`pslverr`=1 in T1 (zero wait states). Memory untouched.
- Address compare is unsigned, full AW width. With `MEM_DEPTH`=2^AW no address errors.

## Structure
- Package `apb_mem_pkg`: state enum (IDLE/STROBE/RD_CAP/DONE), default AW/DW/MEM_DEPTH constants.
- Single module; no sub-module needed.
- Bench instantiates the existing 256×8 memory behind the bridge and drives it with an APB BFM.

## Test plan
- Write 0xA5 to 0x10, then read 0x10: write `pready` in T2 with `pslverr`=0; read `pready` in T3 with `prdata`=0xA5. Check `mem_ce` is one cycle per transfer.
- Address wrap: write 0x00→0xFF and 0xFF→0x00, read both back. Expect 0xFF at addr 0x00 and 0x00 at addr 0xFF.
- `MEM_DEPTH`=128, read 0x80: `pready`=`pslverr`=1 in T1, `mem_ce` never asserted, `prdata` unchanged.
- Back-to-back write 0x3C@0x05 then read 0x05 with no idle cycle between APB transfers: read returns 0x3C. Strobes never overlap.
- Drop `psel` in STROBE of a write of 0x77@0x20: no `pready`. A later read of 0x20 returns 0x77.
- Assert `rst_n`=0 during RD_CAP: all outputs 0 immediately. After release, a read of a previously written address succeeds normally.
